// File: rtl/warp_pkg.sv
// Shared types for the warp front end: instruction width, buffer entry
// layout and the one/two instruction count encoding used by fetch and decode.
package warp_pkg;

  localparam int unsigned WARP_INST_W = 32;

  typedef struct packed {
    logic                   compressed;
    logic [WARP_INST_W-1:0] inst;
  } warp_ibuf_entry_t;

  // Count field on fetch/decode handshakes: number of instructions minus one.
  typedef enum logic {
    WARP_CNT_ONE = 1'b0,
    WARP_CNT_TWO = 1'b1
  } warp_count_e;

endpackage

// File: rtl/warp_ibuf_mem.sv
// Register-array storage for warp_ibuf: two write ports, two asynchronous
// read ports, storage cleared by reset.
module warp_ibuf_mem
  import warp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we0,
  input  logic [AW-1:0]    i_waddr0,
  input  warp_ibuf_entry_t i_wdata0,
  input  logic             i_we1,
  input  logic [AW-1:0]    i_waddr1,
  input  warp_ibuf_entry_t i_wdata1,
  input  logic [AW-1:0]    i_raddr0,
  output warp_ibuf_entry_t o_rdata0,
  input  logic [AW-1:0]    i_raddr1,
  output warp_ibuf_entry_t o_rdata1
);

  warp_ibuf_entry_t mem [DEPTH];

  // The two write addresses are always distinct, so port order is irrelevant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (i_we0) mem[i_waddr0] <= i_wdata0;
      if (i_we1) mem[i_waddr1] <= i_wdata1;
    end
  end

  assign o_rdata0 = mem[i_raddr0];
  assign o_rdata1 = mem[i_raddr1];

endmodule

// File: rtl/warp_ibuf.sv
// Instruction buffer between fetch and decode: circular queue taking and
// presenting up to two instructions per cycle, with single-cycle flush.
module warp_ibuf
  import warp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_fetch_valid,
  output logic                   o_fetch_ready,
  input  logic [WARP_INST_W-1:0] i_inst0,
  input  logic [WARP_INST_W-1:0] i_inst1,
  input  logic [1:0]             i_compressed,
  input  logic                   i_count,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic                   o_count,
  output logic [WARP_INST_W-1:0] o_inst0,
  output logic [WARP_INST_W-1:0] o_inst1,
  output logic [1:0]             o_compressed,
  input  logic                   i_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   occ;

  logic [AW:0]   free_slots;
  logic          enq;
  logic          deq;
  logic [AW:0]   n_in;
  logic [AW:0]   n_out;
  logic [AW:0]   add_cnt;
  logic [AW:0]   sub_cnt;

  warp_ibuf_entry_t wdata0, wdata1, rdata0, rdata1;

  // Ready looks only at registered occupancy, keeping i_ready off this path.
  assign free_slots    = (AW+1)'(DEPTH) - occ;
  assign o_fetch_ready = i_rst_n && (free_slots >= (AW+1)'(2));

  assign o_valid = (occ != '0);
  assign o_count = (occ >= (AW+1)'(2));

  assign enq   = i_fetch_valid && o_fetch_ready && !i_flush;
  assign deq   = o_valid && i_ready && !i_flush;
  assign n_in  = (i_count == WARP_CNT_TWO) ? (AW+1)'(2) : (AW+1)'(1);
  assign n_out = o_count ? (AW+1)'(2) : (AW+1)'(1);

  always_comb begin
    add_cnt = '0;
    sub_cnt = '0;
    if (enq) add_cnt = n_in;
    if (deq) sub_cnt = n_out;
  end

  assign wdata0 = '{compressed: i_compressed[0], inst: i_inst0};
  assign wdata1 = '{compressed: i_compressed[1], inst: i_inst1};

  warp_ibuf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we0    (enq),
    .i_waddr0 (wp),
    .i_wdata0 (wdata0),
    .i_we1    (enq && (i_count == WARP_CNT_TWO)),
    .i_waddr1 (wp + AW'(1)),
    .i_wdata1 (wdata1),
    .i_raddr0 (rp),
    .o_rdata0 (rdata0),
    .i_raddr1 (rp + AW'(1)),
    .o_rdata1 (rdata1)
  );

  assign o_inst0      = rdata0.inst;
  assign o_inst1      = rdata1.inst;
  assign o_compressed = {rdata1.compressed, rdata0.compressed};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else if (i_flush) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (enq) wp <= wp + n_in[AW-1:0];
      if (deq) rp <= rp + n_out[AW-1:0];
      occ <= occ + add_cnt - sub_cnt;
    end
  end

endmodule

// File: tb/tb_warp_ibuf.sv
// Self-checking bench for warp_ibuf: directed scenarios plus a random stream
// against a reference queue model.
module tb_warp_ibuf;
  import warp_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_fetch_valid = 1'b0;
  logic        o_fetch_ready;
  logic [31:0] i_inst0 = '0;
  logic [31:0] i_inst1 = '0;
  logic [1:0]  i_compressed = '0;
  logic        i_count = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        o_count;
  logic [31:0] o_inst0;
  logic [31:0] o_inst1;
  logic [1:0]  o_compressed;
  logic        i_ready = 1'b0;

  warp_ibuf #(.DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_fetch_valid (i_fetch_valid),
    .o_fetch_ready (o_fetch_ready),
    .i_inst0       (i_inst0),
    .i_inst1       (i_inst1),
    .i_compressed  (i_compressed),
    .i_count       (i_count),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .o_count       (o_count),
    .o_inst0       (o_inst0),
    .o_inst1       (o_inst1),
    .o_compressed  (o_compressed),
    .i_ready       (i_ready)
  );

  always #5 i_clk = ~i_clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: scoreboard queue of {compressed, inst} plus pointers.
  logic [32:0] q[$];
  int unsigned mwp = 0;
  int unsigned mrp = 0;
  logic        last_enq = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_e0, prev_e1;
  logic        prev_cnt = 1'b0;
  logic        tp_phase = 1'b0;
  int unsigned tp_cycle = 0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int unsigned sz;
    sz = q.size();
    chk("valid", o_valid, (sz != 0));
    chk("count", o_count, (sz >= 2));
    chk("fetch_ready", o_fetch_ready, ((DEPTH - sz) >= 2));
    chk("occ", 33'(dut.occ), 33'(sz));
    chk("wp", 33'(dut.wp), 33'(mwp));
    chk("rp", 33'(dut.rp), 33'(mrp));
    if (sz >= 1) chk("entry0", {o_compressed[0], o_inst0}, q[0]);
    if (sz >= 2) chk("entry1", {o_compressed[1], o_inst1}, q[1]);
    if (prev_stall) begin
      chk("stable0", {o_compressed[0], o_inst0}, prev_e0);
      if (prev_cnt) chk("stable1", {o_compressed[1], o_inst1}, prev_e1);
    end
    if (tp_phase) begin
      chk("tp_ready", o_fetch_ready, 1'b1);
      if (tp_cycle > 0) chk("tp_count", o_count, 1'b1);
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic cycle(input logic fv, input logic cnt, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] c,
                       input logic rdy, input logic fl);
    int unsigned sz, n_out;
    logic m_ready, m_enq, m_deq;
    i_fetch_valid = fv;
    i_count       = cnt;
    i_inst0       = a;
    i_inst1       = b;
    i_compressed  = c;
    i_ready       = rdy;
    i_flush       = fl;
    #1;
    check_outputs();
    sz      = q.size();
    m_ready = ((DEPTH - sz) >= 2);
    m_enq   = fv && m_ready && !fl;
    m_deq   = (sz != 0) && rdy && !fl;
    n_out   = (sz >= 2) ? 2 : 1;
    prev_stall = (sz != 0) && !rdy && !fl;
    if (sz >= 1) prev_e0 = q[0];
    if (sz >= 2) prev_e1 = q[1];
    prev_cnt = (sz >= 2);
    last_enq = m_enq;
    @(posedge i_clk);
    if (fl) begin
      q.delete();
      mwp = 0;
      mrp = 0;
    end else begin
      if (m_deq) begin
        for (int k = 0; k < int'(n_out); k++) void'(q.pop_front());
        mrp = (mrp + n_out) % DEPTH;
      end
      if (m_enq) begin
        q.push_back({c[0], a});
        if (cnt) q.push_back({c[1], b});
        mwp = (mwp + (cnt ? 2 : 1)) % DEPTH;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, '0, '0, 2'b00, rdy, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rc;
    logic        rcnt, rfv;

    // Reset state
    #2;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_fetch_ready, 1'b0);
    chk("rst_inst0", 33'(o_inst0), 33'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1'b0);

    // Ordering: A single, then pairs B,C and D,E while decode stalls
    cycle(1'b1, 1'b0, 32'hA0A0_0001, 32'h0, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hB0B0_0002, 32'hC0C0_0003, 2'b10, 1'b0, 1'b0);
    chk("ord_inst0_A", 33'(o_inst0), 33'(32'hA0A0_0001));
    chk("ord_inst1_B", 33'(o_inst1), 33'(32'hB0B0_0002));
    chk("ord_count", o_count, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
    chk("ord_inst0_C", 33'(o_inst0), 33'(32'hC0C0_0003));
    chk("ord_count1", o_count, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill to DEPTH-1, then fetch pressure must not write
    cycle(1'b1, 1'b0, 32'h1111_0000, 32'h0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 32'h2000_0000 + i, 32'h3000_0000 + i, 2'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h4000_0000, 32'h0, 2'b01, 1'b0, 1'b0);
    chk("full_ready", o_fetch_ready, 1'b0);
    chk("full_occ", 33'(dut.occ), 33'd7);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 32'hDEAD_0000 + i, 32'hBEEF_0000, 2'b11, 1'b0, 1'b0);
    chk("full_hold_occ", 33'(dut.occ), 33'd7);

    // Drain to wp = rp = 7, then a pair wraps across entries 7 and 0
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("wrap_rp", 33'(dut.rp), 33'd7);
    chk("wrap_wp", 33'(dut.wp), 33'd7);
    cycle(1'b1, 1'b1, 32'h5A5A_0007, 32'hA5A5_0000, 2'b01, 1'b0, 1'b0);
    chk("wrap_x", 33'(o_inst0), 33'(32'h5A5A_0007));
    chk("wrap_y", 33'(o_inst1), 33'(32'hA5A5_0000));
    chk("wrap_mem0", 33'(dut.u_mem.mem[0]), {1'b0, 32'hA5A5_0000});
    idle(1'b1);

    // Flush beats a same-cycle enqueue and dequeue at occ = 4
    cycle(1'b1, 1'b1, 32'h6000_0001, 32'h6000_0002, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h6000_0003, 32'h6000_0004, 2'b00, 1'b0, 1'b0);
    chk("flush_pre_occ", 33'(dut.occ), 33'd4);
    cycle(1'b1, 1'b1, 32'h7777_7777, 32'h8888_8888, 2'b11, 1'b1, 1'b1);
    chk("flush_valid", o_valid, 1'b0);
    cycle(1'b1, 1'b0, 32'h9999_0000, 32'h0, 2'b01, 1'b0, 1'b0);
    chk("flush_mem0", 33'(dut.u_mem.mem[0]), {1'b1, 32'h9999_0000});
    idle(1'b1);

    // Reset mid-stream at occ = 5
    cycle(1'b1, 1'b1, 32'hC000_0001, 32'hC000_0002, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hC000_0003, 32'hC000_0004, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hC000_0005, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("mid_occ5", 33'(dut.occ), 33'd5);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_ready", o_fetch_ready, 1'b0);
    chk("mid_rst_inst0", 33'(o_inst0), 33'd0);
    q.delete();
    mwp = 0;
    mrp = 0;
    prev_stall = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1'b0);

    // Random streaming; fetch holds its output until accepted
    rfv = 1'b0; rcnt = 1'b0; ra = '0; rb = '0; rc = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!rfv || last_enq) begin
        rfv  = ($urandom_range(0, 3) != 0);
        rcnt = 1'($urandom_range(0, 1));
        ra   = $urandom;
        rb   = $urandom;
        rc   = 2'($urandom_range(0, 3));
      end
      cycle(rfv, rcnt, ra, rb, rc, 1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 199) == 0));
      if (q.size() > DEPTH) begin
        miscompares++;
        $error("FAIL model_occ observed=%0d expected<=%0d", q.size(), DEPTH);
      end
    end

    // Sustained two-in/two-out throughput
    cycle(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
    tp_phase = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tp_cycle = i;
      cycle(1'b1, 1'b1, 32'hF000_0000 + 2 * i, 32'hF000_0001 + 2 * i, 2'b10, 1'b1, 1'b0);
    end
    tp_phase = 1'b0;
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/warp_ibuf.md
# warp_ibuf

Instruction buffer between `warp_fetch` and decode. It accepts one or two instructions per cycle from the fetch output handshake and holds them in a circular queue of `DEPTH` entries. It presents the oldest one or two entries to decode through a single valid/ready handshake. Decode stalls therefore do not immediately backpressure fetch, and a branch flush discards every queued instruction in one cycle.

## Interface
- `DEPTH`, default 8: number of instruction entries. Must be a power of two, minimum 4.
- `i_clk`  input  1: the single clock. All state changes on its rising edge.
- `i_rst_n`  input  1: reset, asynchronous and active-low.
- `i_fetch_valid`  input  1: fetch output valid (`o_output_valid` of fetch).
- `o_fetch_ready`  output  1: buffer can accept two entries this cycle (drives fetch `i_output_ready`).
- `i_inst0`  input  32: first fetched instruction.
- `i_inst1`  input  32: second fetched instruction.
- `i_compressed`  input  2: bit k set means instruction k is 16-bit (low half valid).
- `i_count`  input  1: 0 means one instruction (`i_inst0` only); 1 means both.
- `i_flush`  input  1: discard all buffered entries (branch redirect).
- `o_valid`  output  1: at least one entry is presented to decode.
- `o_count`  output  1: 1 means two entries are presented, 0 means one.
- `o_inst0`, `o_inst1`  output  32 each: oldest and second-oldest entry.
- `o_compressed`  output  2: compressed flags matching `o_inst0` and `o_inst1`.
- `i_ready`  input  1: decode accepts every presented entry this cycle.

## Operation
- Storage: `DEPTH` entries, each 33 bits (`{compressed, inst}`).
- Pointers: write pointer `wp` and read pointer `rp`, each `log2(DEPTH)` bits, wrapping modulo `DEPTH`.
- Occupancy: `occ` is `log2(DEPTH)+1` bits, range 0..`DEPTH`.
- Enqueue fires when `enq = i_fetch_valid && o_fetch_ready && !i_flush`.
  - It writes `n_in = 1 + i_count` entries.
  - `i_inst0` goes to `wp` and `i_inst1` to `wp+1`, modulo `DEPTH`.
  - Then `wp += n_in`.
- `o_fetch_ready = i_rst_n && (DEPTH - occ >= 2)`.
  - It depends only on registered `occ`, never on same-cycle dequeue, so there is no combinational path from `i_ready`.
- Presentation:
  - `o_valid = (occ != 0)`.
  - `o_count = (occ >= 2)`.
  - `o_inst0` and `o_compressed[0]` come from `rp`.
  - `o_inst1` and `o_compressed[1]` come from `rp+1`. When `o_count = 0`, `o_inst1` and `o_compressed[1]` are don't-care and the bench must not check them.
- Dequeue fires when `deq = o_valid && i_ready && !i_flush`.
  - It removes `n_out = 1 + o_count` entries: `rp += n_out`.
- Occupancy update: `occ_next = occ + (enq ? n_in : 0) - (deq ? n_out : 0)`.
  - Simultaneous enqueue and dequeue is legal at any occupancy the ready rule permits.
- Flush: when `i_flush` is high, next `occ = 0`, `wp = 0`, `rp = 0`. Same-cycle enqueue and dequeue are ignored. Flush takes priority over everything else.
- Outputs are stable while `o_valid && !i_ready` and no flush, since no entry at `rp`/`rp+1` is overwritten. This holds because an enqueue only fires when at least 2 free slots exist.
- No bypass: an entry becomes visible the cycle after it is written.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `occ = 0`, `wp = 0`, `rp = 0`.
  - `o_valid = 0`, `o_count = 0`.
  - `o_fetch_ready = 0` while `i_rst_n` is low, and 1 in the first cycle after release.
  - `o_inst*` and `o_compressed` are 0 (storage is reset).
- Latency: enqueue at edge N gives `o_valid` in cycle N+1.
- Throughput: two instructions in and two out per cycle sustained, provided decode keeps `i_ready` high.
- Full boundary: when `occ = DEPTH-1` or `DEPTH`, `o_fetch_ready = 0`. Fetch holds its output, which the fetch protocol guarantees.
- Empty boundary: when `occ = 1`, `o_count = 0` and a dequeue removes one entry.
- Wrap-around: a two-entry enqueue at `wp = DEPTH-1` writes entries `DEPTH-1` and 0. The same wrap applies to reads at `rp = DEPTH-1`.
- Reset mid-operation: all buffered entries are lost immediately and outputs return to their reset values.

## Structure
- Shared package `warp_pkg`:
  - `WARP_INST_W = 32`.
  - Entry typedef `warp_ibuf_entry_t` as `{compressed, inst[31:0]}`.
  - The compressed/count encoding, shared with `warp_fetch` and decode.
- One sub-module, `warp_ibuf_mem`: a `DEPTH`-entry register array with 2 write ports (at `wp`, `wp+1`, each with its own enable) and 2 asynchronous read ports (at `rp`, `rp+1`).
- Pointer and occupancy control stay in `warp_ibuf`.

## Test plan
- **Reset:** assert `i_rst_n = 0` mid-stream with `occ = 5` → `o_valid = 0` and `o_fetch_ready = 0` at once; after release `o_fetch_ready = 1`, `occ = 0`.
- **Single/pair ordering:**
  - Enqueue A with count 0, then B, C with count 1, while `i_ready = 0`.
  - Then `o_inst0 = A`, `o_inst1 = B`, `o_count = 1`.
  - Raise `i_ready` for one cycle → `o_inst0 = C`, `o_count = 0`.
- **Fill to full:** with `DEPTH = 8` and `i_ready = 0`, do 3 pair enqueues then 1 single, giving `occ = 7` and `o_fetch_ready = 0`. Then `i_fetch_valid = 1` held for 3 cycles → no write, `occ` stays 7.
- **Wrap:** advance pointers to `wp = rp = 7` (empty), then enqueue pair X, Y → X in entry 7, Y in entry 0; next cycle `o_inst0 = X`, `o_inst1 = Y`.
- **Flush priority:** at `occ = 4`, raise `i_flush` together with a valid pair enqueue and `i_ready = 1` → next cycle `occ = 0`, `o_valid = 0`; the following enqueue lands at entry 0.
- **Streaming:** random count and `i_ready` over 10k cycles against a reference queue model. Check:
  - outputs stay stable under stall;
  - no drops or duplicates;
  - `occ` never exceeds `DEPTH`;
  - sustained 2-per-cycle throughput when `i_ready` is held at 1.
